// File: rtl/memory_bus_initiator.sv
// memory_bus_initiator: turns single 8-byte client loads/stores into bus
// request packets and, for loads, waits for the response tagged with
// SOURCE_ID. Writes retire when the bus accepts them. Reads retire on the
// matching response, or with an error on timeout. Out-of-range addresses
// fail locally and put nothing on the bus.
module memory_bus_initiator #(
  parameter logic [7:0]  SOURCE_ID      = 8'd0,
  parameter logic [63:0] MEM_BYTES      = 64'h0010_0000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [63:0] resp_rdata,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [1:0]  bus_req_type,
  output logic [63:0] bus_req_address,
  output logic [63:0] bus_req_payload,
  output logic [7:0]  bus_req_source,
  input  logic        bus_rsp_valid,
  input  logic [7:0]  bus_rsp_dest,
  input  logic [63:0] bus_rsp_payload,
  output logic [7:0]  stale_rsp_count
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT_CYCLES);
  // Last byte address at which a full 8-byte access still fits in memory.
  localparam logic [63:0]     ADDR_MAX = MEM_BYTES - 64'd8;
  localparam logic [1:0]      TYPE_RD  = 2'd1;
  localparam logic [1:0]      TYPE_WR  = 2'd2;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

  state_t           state_q, state_d;
  logic             write_q, write_d;
  logic [63:0]      addr_q, addr_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [63:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       stale_q, stale_d;
  logic             rsp_hit;

  assign rsp_hit = bus_rsp_valid && (bus_rsp_dest == SOURCE_ID);

  // State, latched request, completion status, timeout and stale counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      stale_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
    end
  end

  // Next-state logic: request latch, bus handshake, response match, timeout.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    stale_d = stale_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          if (req_addr > ADDR_MAX) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = SEND;
          end
        end
      end
      SEND: begin
        // No timeout here: the responder may stall acceptance indefinitely.
        if (bus_req_ready) begin
          if (write_q) begin
            state_d = DONE;
          end else begin
            cnt_d   = '0;
            state_d = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        if (rsp_hit) begin
          rdata_d = bus_rsp_payload;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == TMO) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A response for us outside WAIT_RSP belongs to an abandoned or
    // timed-out read; drop it and count it, saturating at 255.
    if (rsp_hit && (state_q != WAIT_RSP) && (stale_q != 8'hff)) begin
      stale_d = stale_q + 8'd1;
    end
  end

  assign req_ready       = (state_q == IDLE);
  assign bus_req_valid   = (state_q == SEND);
  assign bus_req_type    = bus_req_valid ? (write_q ? TYPE_WR : TYPE_RD) : 2'd0;
  assign bus_req_address = bus_req_valid ? addr_q : 64'd0;
  assign bus_req_payload = (bus_req_valid && write_q) ? wdata_q : 64'd0;
  assign bus_req_source  = SOURCE_ID;
  assign resp_valid      = (state_q == DONE);
  assign resp_error      = resp_valid && err_q;
  assign resp_rdata      = resp_valid ? rdata_q : 64'd0;
  assign stale_rsp_count = stale_q;

endmodule

// File: tb/tb_memory_bus_initiator.sv
// Directed bench for memory_bus_initiator with a completion scoreboard.
module tb_memory_bus_initiator;

  localparam logic [7:0]  SRC   = 8'd0;
  localparam logic [63:0] MEMSZ = 64'h0010_0000;
  localparam int          TMO   = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_error;
  logic [63:0] resp_rdata;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [1:0]  bus_req_type;
  logic [63:0] bus_req_address;
  logic [63:0] bus_req_payload;
  logic [7:0]  bus_req_source;
  logic        bus_rsp_valid;
  logic [7:0]  bus_rsp_dest;
  logic [63:0] bus_rsp_payload;
  logic [7:0]  stale_rsp_count;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  memory_bus_initiator #(
    .SOURCE_ID(SRC), .MEM_BYTES(MEMSZ), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_type(bus_req_type), .bus_req_address(bus_req_address),
    .bus_req_payload(bus_req_payload), .bus_req_source(bus_req_source),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_dest(bus_rsp_dest),
    .bus_rsp_payload(bus_rsp_payload), .stale_rsp_count(stale_rsp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic push(input logic err, input logic [63:0] rdata);
    exp_t e;
    e.err   = err;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Called in the cycle a completion is due: pops the oldest expectation.
  task automatic check_resp(input string tag);
    exp_t e;
    chk1({tag, "_valid"}, resp_valid, 1'b1);
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk1({tag, "_error"}, resp_error, e.err);
      chk64({tag, "_rdata"}, resp_rdata, e.rdata);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk1({tag, "_req_ready"}, req_ready, 1'b1);
    chk1({tag, "_bus_req_valid"}, bus_req_valid, 1'b0);
    chk1({tag, "_resp_valid"}, resp_valid, 1'b0);
    chk1({tag, "_resp_error"}, resp_error, 1'b0);
    chk64({tag, "_resp_rdata"}, resp_rdata, 64'd0);
    chk64({tag, "_bus_type"}, 64'(bus_req_type), 64'd0);
    chk64({tag, "_bus_addr"}, bus_req_address, 64'd0);
    chk64({tag, "_bus_payload"}, bus_req_payload, 64'd0);
    chk64({tag, "_bus_source"}, 64'(bus_req_source), 64'(SRC));
    chk64({tag, "_stale"}, 64'(stale_rsp_count), 64'd0);
  endtask

  // Presents one request for a single IDLE cycle; returns at cycle 1.
  task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 64'd0;
    req_wdata = 64'd0;
  endtask

  task automatic drive_rsp(input logic v, input logic [7:0] dest, input logic [63:0] p);
    bus_rsp_valid   = v;
    bus_rsp_dest    = dest;
    bus_rsp_payload = p;
  endtask

  // Hard stop in case the sequence ever wedges.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = 64'd0;
    req_wdata = 64'd0;
    bus_req_ready = 1'b0;
    drive_rsp(1'b0, 8'd0, 64'd0);
    tick();
    tick();
    check_reset_outputs("rst0");
    rst_n = 1'b1;
    tick();

    // Posted write, bus ready immediately.
    bus_req_ready = 1'b1;
    push(1'b0, 64'd0);
    chk1("wr_req_ready", req_ready, 1'b1);
    issue(1'b1, 64'h100, 64'h8877665544332211);
    chk1("wr_bus_valid", bus_req_valid, 1'b1);
    chk64("wr_bus_type", 64'(bus_req_type), 64'd2);
    chk64("wr_bus_addr", bus_req_address, 64'h100);
    chk64("wr_bus_payload", bus_req_payload, 64'h8877665544332211);
    chk64("wr_bus_source", 64'(bus_req_source), 64'(SRC));
    chk1("wr_req_ready_busy", req_ready, 1'b0);
    tick();
    check_resp("wr");
    tick();
    chk1("wr_idle_again", req_ready, 1'b1);
    chk1("wr_resp_pulse", resp_valid, 1'b0);

    // Read with five stalled cycles, then response two cycles after accept.
    bus_req_ready = 1'b0;
    push(1'b0, 64'h8877665544332211);
    issue(1'b0, 64'h100, 64'hdead_beef_0000_0000);
    for (int i = 0; i < 5; i++) begin
      chk1("rd_stall_valid", bus_req_valid, 1'b1);
      chk64("rd_stall_addr", bus_req_address, 64'h100);
      chk64("rd_stall_type", 64'(bus_req_type), 64'd1);
      chk64("rd_stall_payload", bus_req_payload, 64'd0);
      tick();
    end
    bus_req_ready = 1'b1;
    chk1("rd_accept_valid", bus_req_valid, 1'b1);
    tick();
    bus_req_ready = 1'b0;
    chk1("rd_wait_bus_idle", bus_req_valid, 1'b0);
    chk1("rd_wait_no_resp", resp_valid, 1'b0);
    tick();
    drive_rsp(1'b1, SRC, 64'h8877665544332211);
    tick();
    drive_rsp(1'b0, 8'd0, 64'd0);
    check_resp("rd_stall");
    chk64("rd_stall_stale", 64'(stale_rsp_count), 64'd0);
    tick();

    // Foreign-destination response ignored, then ours completes the read.
    bus_req_ready = 1'b1;
    push(1'b0, 64'h0123_4567_89ab_cdef);
    issue(1'b0, 64'h200, 64'd0);
    tick();
    drive_rsp(1'b1, SRC + 8'd1, 64'hffff_ffff_ffff_ffff);
    tick();
    chk1("fd_not_done", resp_valid, 1'b0);
    drive_rsp(1'b1, SRC, 64'h0123_4567_89ab_cdef);
    tick();
    drive_rsp(1'b0, 8'd0, 64'd0);
    check_resp("fd");
    chk64("fd_stale", 64'(stale_rsp_count), 64'd0);
    tick();

    // Range error at MEM_BYTES-7: completes at cycle 1, no bus traffic.
    push(1'b1, 64'd0);
    issue(1'b0, MEMSZ - 64'd7, 64'd0);
    chk1("rng_bus_valid", bus_req_valid, 1'b0);
    check_resp("rng");
    tick();
    chk1("rng_bus_valid_after", bus_req_valid, 1'b0);
    chk1("rng_idle", req_ready, 1'b1);

    // MEM_BYTES-8 is the last legal address.
    push(1'b0, 64'h5a5a_a5a5_0f0f_f0f0);
    issue(1'b0, MEMSZ - 64'd8, 64'd0);
    chk1("edge_bus_valid", bus_req_valid, 1'b1);
    chk64("edge_bus_addr", bus_req_address, MEMSZ - 64'd8);
    tick();
    drive_rsp(1'b1, SRC, 64'h5a5a_a5a5_0f0f_f0f0);
    tick();
    drive_rsp(1'b0, 8'd0, 64'd0);
    check_resp("edge");
    tick();

    // Timeout: four WAIT_RSP cycles with no match, then an error completion.
    push(1'b1, 64'd0);
    issue(1'b0, 64'h300, 64'd0);
    tick();
    for (int i = 0; i < TMO; i++) begin
      chk1("tmo_pending", resp_valid, 1'b0);
      tick();
    end
    check_resp("tmo");
    tick();
    drive_rsp(1'b1, SRC, 64'h1111);
    tick();
    drive_rsp(1'b0, 8'd0, 64'd0);
    chk64("tmo_stale", 64'(stale_rsp_count), 64'd1);

    // Reset while in WAIT_RSP; the abandoned read's response is stale.
    issue(1'b0, 64'h100, 64'd0);
    tick();
    chk1("rstw_in_wait", bus_req_valid, 1'b0);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("rstw");
    rst_n = 1'b1;
    drive_rsp(1'b1, SRC, 64'h2222);
    tick();
    drive_rsp(1'b0, 8'd0, 64'd0);
    chk64("rstw_late_stale", 64'(stale_rsp_count), 64'd1);

    // Reset while in SEND with the bus stalled.
    bus_req_ready = 1'b0;
    issue(1'b1, 64'h400, 64'hcafe);
    chk1("rsts_in_send", bus_req_valid, 1'b1);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("rsts");
    rst_n = 1'b1;
    tick();

    // Fresh write after reset.
    bus_req_ready = 1'b1;
    push(1'b0, 64'd0);
    issue(1'b1, 64'h500, 64'h0a0b_0c0d_0e0f_1011);
    chk1("post_bus_valid", bus_req_valid, 1'b1);
    chk64("post_bus_addr", bus_req_address, 64'h500);
    chk64("post_bus_payload", bus_req_payload, 64'h0a0b_0c0d_0e0f_1011);
    tick();
    check_resp("post");
    tick();

    // Stale counter saturates at 255.
    drive_rsp(1'b1, SRC, 64'd0);
    for (int i = 0; i < 300; i++) tick();
    drive_rsp(1'b0, 8'd0, 64'd0);
    tick();
    chk64("stale_sat", 64'(stale_rsp_count), 64'd255);
    chk64("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
